// File: rtl/cnt_sched.sv
`default_nettype none
// ============================================================================
// Module      : cnt_sched
// Description : Round-robin scheduler that hands an external counter to one
//               of two requesters. It loads the owner's start value, then
//               enables counting until the owner's limit and pulses done.
//               The optional abort/aborted ports are compiled in by the
//               CNT_SCHED_ABORT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_sched #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] start0,
    input  logic [WIDTH-1:0] start1,
    input  logic [WIDTH-1:0] limit0,
    input  logic [WIDTH-1:0] limit1,
`ifdef CNT_SCHED_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic             ctr_load,
    output logic             ctr_enab,
    output logic [WIDTH-1:0] ctr_cnt_in,
    input  logic [WIDTH-1:0] ctr_cnt_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_owner;
    logic             r_last;
    logic [WIDTH-1:0] r_start;
    logic [WIDTH-1:0] r_limit;

    logic             w_any_req;
    logic             w_pick;
    logic             w_abort;
    logic             w_aborted;
    logic             w_load;
    logic             w_enab;
    logic             w_at_limit;

`ifdef CNT_SCHED_ABORT_EN
    assign w_abort = abort;
    assign aborted = w_aborted;
`else
    assign w_abort = 1'b0;
`endif

    assign w_any_req  = req0 | req1;
    // On a tie the requester that did not own the counter last wins.
    assign w_pick     = (req0 && req1) ? ~r_last : req1;
    assign w_at_limit = (ctr_cnt_out == r_limit);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_enab      = 1'b0;
        w_aborted   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_abort) begin
                    w_aborted   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_abort) begin
                    w_aborted   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_at_limit) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_enab      = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_start <= '0;
            r_limit <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Owner's operands are captured only at grant; later changes are ignored.
            if (r_state == S_IDLE && w_any_req) begin
                r_owner <= w_pick;
                r_start <= w_pick ? start1 : start0;
                r_limit <= w_pick ? limit1 : limit0;
            end
            if (r_state == S_DONE || w_aborted) begin
                r_last <= r_owner;
            end
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign gnt0       = busy & ~r_owner;
    assign gnt1       = busy &  r_owner;
    assign done0      = (r_state == S_DONE) & ~r_owner;
    assign done1      = (r_state == S_DONE) &  r_owner;
    assign ctr_load   = w_load;
    assign ctr_enab   = w_enab;
    assign ctr_cnt_in = r_start;

endmodule
`default_nettype wire

// File: tb/tb_cnt_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnt_sched
// Description : Self-checking bench for cnt_sched with a behavioural counter
//               model; abort checks are built when CNT_SCHED_ABORT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnt_sched;

    localparam int WIDTH = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1;
    logic [WIDTH-1:0] start0, start1, limit0, limit1;
    logic             gnt0, gnt1, done0, done1, busy;
    logic             ctr_load, ctr_enab;
    logic [WIDTH-1:0] ctr_cnt_in;
    logic [WIDTH-1:0] ctr_q = '0;
`ifdef CNT_SCHED_ABORT_EN
    logic             abort;
    logic             aborted;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External counter: load has priority over enable, wraps modulo 2^WIDTH.
    always @(posedge clk) begin
        if (ctr_load)      ctr_q <= ctr_cnt_in;
        else if (ctr_enab) ctr_q <= ctr_q + 5'd1;
    end

    cnt_sched #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .req1        (req1),
        .start0      (start0),
        .start1      (start1),
        .limit0      (limit0),
        .limit1      (limit1),
`ifdef CNT_SCHED_ABORT_EN
        .abort       (abort),
        .aborted     (aborted),
`endif
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .done0       (done0),
        .done1       (done1),
        .busy        (busy),
        .ctr_load    (ctr_load),
        .ctr_enab    (ctr_enab),
        .ctr_cnt_in  (ctr_cnt_in),
        .ctr_cnt_out (ctr_q)
    );

    typedef struct {
        logic             r0, r1;
        logic [WIDTH-1:0] s0, l0, s1, l1;
        logic             owner;
        int               gnt_cyc;
        int               enab_cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after gnt drops.
    task automatic run_vec(input vec_t v, input int idx);
        int gc, ec, dc, guard;
        req0 = v.r0; req1 = v.r1;
        start0 = v.s0; limit0 = v.l0; start1 = v.s1; limit1 = v.l1;
        @(negedge clk);
        check($sformatf("v%0d gnt_owner", idx), v.owner ? gnt1 : gnt0, 1);
        check($sformatf("v%0d gnt_other", idx), v.owner ? gnt0 : gnt1, 0);
        check($sformatf("v%0d load", idx), ctr_load, 1);
        check($sformatf("v%0d cnt_in", idx), ctr_cnt_in, v.owner ? v.s1 : v.s0);
        gc = 0; ec = 0; dc = 0; guard = 0;
        while ((gnt0 || gnt1) && guard < 80) begin
            gc++;
            if (ctr_enab) ec++;
            if (done0 || done1) begin
                dc++;
                check($sformatf("v%0d done_owner", idx), v.owner ? done1 : done0, 1);
                check($sformatf("v%0d done_other", idx), v.owner ? done0 : done1, 0);
                check($sformatf("v%0d cnt_at_done", idx), ctr_q, v.owner ? v.l1 : v.l0);
                req0 = 1'b0; req1 = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        check($sformatf("v%0d gnt_cycles", idx), gc, v.gnt_cyc);
        check($sformatf("v%0d enab_cycles", idx), ec, v.enab_cyc);
        check($sformatf("v%0d done_pulses", idx), dc, 1);
    endtask

    initial begin
        int order[$];
        int gap, guard, gc, dc;
        logic prev_gnt;

        //          r0  r1  s0     l0     s1     l1     own  gnt enab
        vecs[0] = '{1'b1, 1'b0, 5'd3,  5'd7,  5'd0,  5'd0,  1'b0, 7,  4};
        vecs[1] = '{1'b1, 1'b1, 5'd12, 5'd12, 5'd5,  5'd6,  1'b1, 4,  1};
        vecs[2] = '{1'b1, 1'b1, 5'd12, 5'd12, 5'd9,  5'd9,  1'b0, 3,  0};
        vecs[3] = '{1'b0, 1'b1, 5'd0,  5'd0,  5'd30, 5'd1,  1'b1, 6,  3};
        vecs[4] = '{1'b1, 1'b1, 5'd31, 5'd0,  5'd4,  5'd4,  1'b0, 4,  1};
        vecs[5] = '{1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  5'd31, 1'b1, 34, 31};

        rst = 1'b1; req0 = 0; req1 = 0;
        start0 = 0; start1 = 0; limit0 = 0; limit1 = 0;
`ifdef CNT_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        #2;
        check("rst gnt", {gnt0, gnt1}, 0);
        check("rst done", {done0, done1}, 0);
        check("rst busy", busy, 0);
        check("rst ctr_ctl", {ctr_load, ctr_enab}, 0);
        check("rst cnt_in", ctr_cnt_in, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Continuous contention from reset: alternate grants, one idle cycle between.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req0 = 1; req1 = 1; start0 = 5; limit0 = 5; start1 = 9; limit1 = 9;
        gap = 0; guard = 0; prev_gnt = 1'b0;
        while (order.size() < 4 && guard < 60) begin
            @(negedge clk);
            guard++;
            if (!busy) gap++;
            if ((gnt0 || gnt1) && !prev_gnt) begin
                if (order.size() > 0) check("rr idle_gap", gap, 1);
                order.push_back(gnt1 ? 1 : 0);
                gap = 0;
            end
            prev_gnt = gnt0 || gnt1;
        end
        check("rr grants", order.size(), 4);
        while (order.size() < 4) order.push_back(-1);
        check("rr order0", order[0], 0);
        check("rr order1", order[1], 1);
        check("rr order2", order[2], 0);
        check("rr order3", order[3], 1);
        req0 = 0; req1 = 0;
        guard = 0;
        while (busy && guard < 20) begin @(negedge clk); guard++; end
        check("rr drain", busy, 0);

        // Operand changes and early req drop during a job are ignored.
        req0 = 1; start0 = 2; limit0 = 4;
        @(negedge clk);
        check("hold gnt0", gnt0, 1);
        req0 = 0; start0 = 20; limit0 = 25;
        gc = 0; dc = 0; guard = 0;
        while (gnt0 && guard < 40) begin
            gc++;
            if (done0) begin
                dc++;
                check("hold cnt_at_done", ctr_q, 4);
            end
            @(negedge clk);
            guard++;
        end
        check("hold gnt_cycles", gc, 5);
        check("hold done_pulses", dc, 1);

        // Asynchronous reset mid-RUN discards the job.
        req0 = 1; start0 = 0; limit0 = 10;
        @(negedge clk);
        req0 = 0;
        repeat (3) @(negedge clk);
        check("arst pre enab", ctr_enab, 1);
        #1 rst = 1'b1;
        #1;
        check("arst outputs", {gnt0, gnt1, done0, done1, busy, ctr_load, ctr_enab}, 0);
        @(negedge clk);
        rst = 1'b0;
        dc = 0;
        repeat (15) begin
            @(negedge clk);
            if (done0 || done1 || busy) dc++;
        end
        check("arst no_done", dc, 0);

`ifdef CNT_SCHED_ABORT_EN
        // Abort in the third RUN cycle.
        req0 = 1; start0 = 0; limit0 = 20;
        @(negedge clk);
        check("abort gnt0", gnt0, 1);
        req0 = 0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        #1;
        check("abort pulse", aborted, 1);
        check("abort enab", ctr_enab, 0);
        check("abort done", done0, 0);
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("abort gnt_drop", gnt0, 0);
        check("abort pulse_end", aborted, 0);
        check("abort busy", busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
